// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
// Sequences word-aligned instruction fetches onto a req/gnt/rvalid memory
// channel, keeps up to MAX_OUTSTANDING granted requests in flight and
// buffers returned instructions (with their addresses) in a FIFO_DEPTH
// prefetch FIFO that feeds decode over a valid/ready handshake.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   boot_addr_i              start address, sampled while rst is high
//   fetch_en_i               allows new requests to be issued
//   redirect_i/_addr_i       one-cycle flush and restart at a new target
//   instr_req_o/_addr_o      request channel (held stable until granted)
//   instr_gnt_i              memory accepted the request
//   instr_rvalid_i/_rdata_i  in-order response channel
//   fetch_valid_o/_instr_o/_addr_o, fetch_ready_i   decode-side handshake
//   busy_o                   requests in flight, responses to drop, or draining
//
// state | meaning
// IDLE  | no request driven, waiting for fetch_en_i
// RUN   | issuing sequential requests whenever credit allows
// DRAIN | redirect arrived while a request was un-granted; hold it until
//       | granted, drop its response, then restart at the new target

module instr_fetch_ctrl #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ready_i,
  output logic        busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [31:0]   pc, pc_n, redir_tgt;
  logic [CW-1:0] outst, outst_n, discard, discard_n, count, count_n, aq_wr_idx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          grant, hold, rv_ok, push, pop, dis_dec, dis_inc, credit_n;

  // addresses of granted requests, head = oldest
  logic [31:0] aq [MAX_OUTSTANDING];
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_addr  [FIFO_DEPTH];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{boot_addr_i[1:0], redirect_addr_i[1:0]};

  always_comb begin
    grant     = instr_req_o & instr_gnt_i;
    hold      = instr_req_o & ~instr_gnt_i;
    // a response with nothing in flight is a protocol error and is ignored
    rv_ok     = instr_rvalid_i & (outst != '0);
    pop       = fetch_valid_o & fetch_ready_i;
    push      = rv_ok & (discard == '0) & ~redirect_i;
    redir_tgt = {redirect_addr_i[31:2], 2'b00};
    aq_wr_idx = outst - CW'(rv_ok);

    outst_n = outst + CW'(grant) - CW'(rv_ok);
    count_n = redirect_i ? '0 : count + CW'(push) - CW'(pop);

    // the grant that ends DRAIN belongs to the old stream
    dis_dec   = rv_ok & (discard != '0);
    dis_inc   = grant & (state == DRAIN);
    discard_n = discard - CW'(dis_dec) + CW'(dis_inc);
    if (redirect_i) discard_n = outst_n;

    // in DRAIN pc already holds the redirect target
    pc_n = pc;
    if (grant && state != DRAIN) pc_n = pc + 32'd4;
    if (redirect_i) pc_n = redir_tgt;

    // credit evaluated on next-cycle occupancy so the registered request
    // never over-commits FIFO space
    credit_n = (outst_n < MAX_W) &&
               (({1'b0, outst_n} + {1'b0, count_n}) < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= {boot_addr_i[31:2], 2'b00};
      instr_req_o  <= 1'b0;
      instr_addr_o <= '0;
      outst        <= '0;
      discard      <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) aq[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_addr[i]  <= '0;
      end
    end else begin
      pc      <= pc_n;
      outst   <= outst_n;
      discard <= discard_n;
      count   <= count_n;

      case (state)
        IDLE: begin
          if (fetch_en_i) begin
            state       <= RUN;
            instr_req_o <= credit_n;
            if (credit_n) instr_addr_o <= pc_n;
          end else begin
            instr_req_o <= 1'b0;
          end
        end
        RUN: begin
          if (hold) begin
            // pending request stays on the bus, whatever else happens
            if (redirect_i) state <= DRAIN;
          end else if (!fetch_en_i) begin
            state       <= IDLE;
            instr_req_o <= 1'b0;
          end else begin
            instr_req_o <= credit_n;
            if (credit_n) instr_addr_o <= pc_n;
          end
        end
        DRAIN: begin
          if (!hold) begin
            if (fetch_en_i) begin
              state       <= RUN;
              instr_req_o <= credit_n;
              if (credit_n) instr_addr_o <= pc_n;
            end else begin
              state       <= IDLE;
              instr_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase

      for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
        if (rv_ok) aq[i] <= aq[i + 1];
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (grant && aq_wr_idx == CW'(i)) aq[i] <= instr_addr_o;

      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= instr_rdata_i;
          fifo_addr[wr_ptr]  <= aq[0];
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign fetch_valid_o = (count != '0);
  assign fetch_instr_o = fifo_instr[rd_ptr];
  assign fetch_addr_o  = fifo_addr[rd_ptr];
  assign busy_o        = (outst != '0) || (discard != '0) || (state == DRAIN);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: memory with random grant/latency, random
// decode back-pressure and redirects, checked against a stream-level model.
module tb_instr_fetch_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_addr_i;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ready_i;
  logic        busy_o;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o), .fetch_addr_o(fetch_addr_o),
    .fetch_ready_i(fetch_ready_i), .busy_o(busy_o));

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  int gnt_pct, ready_pct, lat_min, lat_max;
  bit redir_pend;
  logic [31:0] redir_tgt;

  // memory and model state
  logic [31:0] q_data[$];
  int          q_rdy[$];
  logic [31:0] glog[$];
  int          cyc = 0;
  int          last_rdy, m_outst, n_deliv;
  logic [31:0] exp_issue, exp_deliv, drain_tgt, pend_addr, first_addr;
  bit          drain, pend, flush_chk, watch_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset(input logic [31:0] boot);
    rst = 1'b1; boot_addr_i = boot;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    redirect_i = 1'b0; redirect_addr_i = '0; fetch_ready_i = 1'b0;
    q_data.delete(); q_rdy.delete(); glog.delete();
    m_outst = 0; last_rdy = 0; drain = 0; pend = 0; flush_chk = 0;
    redir_pend = 0; watch_first = 0;
    exp_issue = {boot[31:2], 2'b00};
    exp_deliv = exp_issue;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req",    32'(instr_req_o),   32'd0);
    chk("rst_addr",   instr_addr_o,       32'd0);
    chk("rst_valid",  32'(fetch_valid_o), 32'd0);
    chk("rst_instr",  fetch_instr_o,      32'd0);
    chk("rst_faddr",  fetch_addr_o,       32'd0);
    chk("rst_busy",   32'(busy_o),        32'd0);
  endtask

  // one clock: drive at negedge, check, advance model, wait for next negedge
  task automatic step();
    logic g, rv, hs;
    logic [31:0] tgt;
    int r;
    instr_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    rv = (q_data.size() != 0) && (q_rdy[0] <= cyc);
    instr_rvalid_i = rv;
    instr_rdata_i  = rv ? q_data[0] : $urandom();
    fetch_ready_i  = ($urandom_range(0, 99) < ready_pct);
    redirect_i      = redir_pend;
    redirect_addr_i = redir_pend ? redir_tgt : $urandom();
    redir_pend = 0;

    if (flush_chk) chk("flush_valid", 32'(fetch_valid_o), 32'd0);
    flush_chk = 0;
    if (pend) begin
      chk("hold_req",  32'(instr_req_o), 32'd1);
      chk("hold_addr", instr_addr_o, pend_addr);
    end
    chk("busy", 32'(busy_o), 32'((m_outst != 0) || drain));

    g  = instr_req_o & instr_gnt_i;
    hs = fetch_valid_o & fetch_ready_i;
    pend = instr_req_o & ~instr_gnt_i;
    pend_addr = instr_addr_o;

    if (g) begin
      chk("grant_addr", instr_addr_o, exp_issue);
      r = cyc + $urandom_range(lat_min, lat_max);
      if (r <= last_rdy) r = last_rdy + 1;
      last_rdy = r;
      q_data.push_back(mem_data(instr_addr_o));
      q_rdy.push_back(r);
      glog.push_back(instr_addr_o);
      m_outst++;
      if (drain) begin
        drain = 0;
        exp_issue = drain_tgt;
      end else begin
        exp_issue = exp_issue + 32'd4;
      end
    end
    if (rv) begin
      void'(q_data.pop_front());
      void'(q_rdy.pop_front());
      m_outst--;
    end
    if (hs) begin
      chk("deliv_addr", fetch_addr_o, exp_deliv);
      chk("deliv_data", fetch_instr_o, mem_data(exp_deliv));
      exp_deliv = exp_deliv + 32'd4;
      n_deliv++;
      if (watch_first) begin
        first_addr = fetch_addr_o;
        watch_first = 0;
      end
    end
    if (redirect_i) begin
      tgt = {redirect_addr_i[31:2], 2'b00};
      exp_deliv = tgt;
      flush_chk = 1;
      if (instr_req_o && !instr_gnt_i) begin
        drain = 1;
        drain_tgt = tgt;
      end else begin
        exp_issue = tgt;
      end
    end
    chk("outst_max", 32'(m_outst <= MAX_OUT), 32'd1);

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int bubbles, d0, n0;
    bit seen;
    logic [31:0] a;
    n_deliv = 0;

    // 1: zero-wait streaming from an unaligned boot address
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    fetch_en_i = 1'b1;
    do_reset(32'h0000_0083);
    watch_first = 1; bubbles = 0; seen = 0; d0 = n_deliv;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seen && !fetch_valid_o) bubbles++;
      if (fetch_valid_o) seen = 1;
    end
    chk("t1_seen", 32'(seen), 32'd1);
    chk("t1_bubbles", bubbles, 0);
    chk("t1_first", first_addr, 32'h80);
    chk("t1_deliv", 32'(n_deliv - d0 >= 15), 32'd1);
    chk("t1_glog0", glog[0], 32'h80);
    chk("t1_glog1", glog[1], 32'h84);

    // 2: decode stalled, credit limits grants to FIFO capacity
    ready_pct = 0;
    do_reset(32'h0000_0080);
    repeat (15) step();
    chk("t2_grants", glog.size(), 4);
    chk("t2_req", 32'(instr_req_o), 32'd0);
    chk("t2_valid", 32'(fetch_valid_o), 32'd1);
    chk("t2_head_addr", fetch_addr_o, 32'h80);
    chk("t2_head_data", fetch_instr_o, mem_data(32'h80));
    ready_pct = 100; step(); ready_pct = 0;
    n0 = glog.size();
    repeat (10) step();
    chk("t2_one_more", glog.size() - n0, 1);

    // 3: grant withheld, request and address hold
    gnt_pct = 0; ready_pct = 100;
    do_reset(32'h0000_1000);
    for (int i = 0; i < 10 && !instr_req_o; i++) step();
    chk("t3_req_up", 32'(instr_req_o), 32'd1);
    a = instr_addr_o;
    chk("t3_addr", a, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_req", 32'(instr_req_o), 32'd1);
      chk("t3_addr_hold", instr_addr_o, a);
    end
    gnt_pct = 100;
    step();
    chk("t3_next_req", 32'(instr_req_o), 32'd1);
    chk("t3_next_addr", instr_addr_o, 32'h1004);

    // 4: redirect with two responses in flight
    lat_min = 6; lat_max = 6;
    do_reset(32'h0000_0100);
    for (int i = 0; i < 20 && m_outst != 2; i++) step();
    chk("t4_two_out", m_outst, 2);
    chk("t4_glog", glog[1], 32'h104);
    d0 = n_deliv;
    redir_pend = 1; redir_tgt = 32'h0000_0202; fetch_en_i = 1'b0; watch_first = 1;
    step();
    chk("t4_busy_discard", 32'(busy_o), 32'd1);
    for (int i = 0; i < 30 && m_outst != 0; i++) step();
    chk("t4_drained", m_outst, 0);
    chk("t4_busy_low", 32'(busy_o), 32'd0);
    chk("t4_none_deliv", n_deliv - d0, 0);
    fetch_en_i = 1'b1;
    for (int i = 0; i < 40 && n_deliv == d0; i++) step();
    chk("t4_first", first_addr, 32'h200);

    // 5: redirect while a request is pending un-granted
    gnt_pct = 0; lat_min = 2; lat_max = 2;
    do_reset(32'h0000_0040);
    for (int i = 0; i < 10 && !instr_req_o; i++) step();
    chk("t5_req_addr", instr_addr_o, 32'h40);
    d0 = n_deliv;
    redir_pend = 1; redir_tgt = 32'h0000_0300; watch_first = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_drain_req", 32'(instr_req_o), 32'd1);
      chk("t5_drain_addr", instr_addr_o, 32'h40);
      chk("t5_drain_busy", 32'(busy_o), 32'd1);
    end
    gnt_pct = 100;
    for (int i = 0; i < 20 && glog.size() < 2; i++) step();
    chk("t5_glog_n", 32'(glog.size() >= 2), 32'd1);
    if (glog.size() >= 2) begin
      chk("t5_g0", glog[0], 32'h40);
      chk("t5_g1", glog[1], 32'h300);
    end
    for (int i = 0; i < 40 && n_deliv == d0; i++) step();
    chk("t5_first", first_addr, 32'h300);

    // 6: address wrap, and fetch_en falling under a pending request
    lat_min = 1; lat_max = 1;
    do_reset(32'hFFFF_FFF8);
    for (int i = 0; i < 20 && glog.size() < 3; i++) step();
    chk("t6_glog_n", 32'(glog.size() >= 3), 32'd1);
    if (glog.size() >= 3) begin
      chk("t6_g0", glog[0], 32'hFFFF_FFF8);
      chk("t6_g1", glog[1], 32'hFFFF_FFFC);
      chk("t6_g2", glog[2], 32'h0000_0000);
    end
    gnt_pct = 0;
    for (int i = 0; i < 10 && !instr_req_o; i++) step();
    a = instr_addr_o;
    fetch_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_keep_req", 32'(instr_req_o), 32'd1);
      chk("t6_keep_addr", instr_addr_o, a);
    end
    gnt_pct = 100;
    repeat (3) step();
    chk("t6_req_off", 32'(instr_req_o), 32'd0);
    for (int i = 0; i < 20 && busy_o; i++) step();
    chk("t6_idle", 32'(busy_o), 32'd0);

    // 7: random traffic, redirects and enable toggling
    fetch_en_i = 1'b1;
    do_reset($urandom());
    d0 = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct   = $urandom_range(30, 100);
        ready_pct = $urandom_range(20, 100);
        lat_min   = 1;
        lat_max   = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 99) < 3) begin
        redir_pend = 1;
        redir_tgt  = $urandom();
      end
      if ($urandom_range(0, 99) < 2) fetch_en_i = ~fetch_en_i;
      step();
    end
    chk("t7_deliv", 32'(n_deliv - d0 > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
